// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, op codes and sequencer states for the Gray-input ALU path
package alu_pkg;
  localparam int DATA_W = 4;
  localparam int OP_W = 2;
  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_AND = 2'd2;
  localparam logic [OP_W-1:0] OP_OR = 2'd3;
  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, SETTLE, HOLD} seq_state_t;
endpackage

// File: rtl/bin_to_gray.sv
// bin_to_gray: combinational binary to reflected Gray code conversion
module bin_to_gray
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] b,
  output logic [W-1:0] g
);
  assign g = b ^ (b >> 1);
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: three-beat operand loader feeding the Gray ALU core and capturing its result
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_data,
  output logic [3:0]        g1,
  output logic [3:0]        g2,
  output logic [1:0]        op,
  input  logic [3:0]        alu_r,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_data,
  output logic              res_zero,
  output logic              res_ovf,
  output logic [CNT_W-1:0]  op_count
);
  seq_state_t state, state_nxt;
  logic [3:0] cnt;
  logic [DATA_W-1:0] gray_a, gray_b;
  logic acc, hs;
  bin_to_gray u_gray_a (.b(in_data), .g(gray_a));
  bin_to_gray u_gray_b (.b(in_data), .g(gray_b));
  assign in_ready = state == LOAD_A || state == LOAD_B || state == LOAD_OP;
  assign res_valid = state == HOLD;
  assign acc = in_valid && in_ready;
  assign hs = res_valid && res_ready;
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  state_nxt = acc ? LOAD_B : LOAD_A;
      LOAD_B:  state_nxt = acc ? LOAD_OP : LOAD_B;
      LOAD_OP: state_nxt = acc ? SETTLE : LOAD_OP;
      SETTLE:  state_nxt = cnt == 4'd0 ? HOLD : SETTLE;
      HOLD:    state_nxt = hs ? LOAD_A : HOLD;
      default: state_nxt = LOAD_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else state <= state_nxt;
  end
  // Result registers only move on the sample edge, so they stay stable through HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      g1 <= '0;
      g2 <= '0;
      op <= '0;
      cnt <= '0;
      res_data <= '0;
      res_zero <= 1'b0;
      res_ovf <= 1'b0;
      op_count <= '0;
    end else begin
      if (acc && state == LOAD_A) g1 <= gray_a;
      if (acc && state == LOAD_B) g2 <= gray_b;
      if (acc && state == LOAD_OP) begin
        op <= in_data[OP_W-1:0];
        cnt <= 4'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE) begin
        if (cnt == 4'd0) begin
          res_data <= alu_r;
          res_zero <= alu_zero;
          res_ovf <= alu_overflow;
        end else cnt <= cnt - 4'd1;
      end
      if (hs) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed and randomized checks of two sequencer configurations against a reference model
module tb_alu_operand_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, res_ready, alu_zero, alu_overflow;
  logic [3:0] in_data, alu_r;
  bit which;
  logic in_ready_a, res_valid_a, res_zero_a, res_ovf_a;
  logic [3:0] g1_a, g2_a, res_data_a;
  logic [1:0] op_a, op_count_a;
  logic in_ready_b, res_valid_b, res_zero_b, res_ovf_b;
  logic [3:0] g1_b, g2_b, res_data_b;
  logic [1:0] op_b;
  logic [7:0] op_count_b;
  logic in_ready, res_valid, res_zero, res_ovf;
  logic [3:0] g1, g2, res_data;
  logic [1:0] op;
  logic [7:0] op_count;
  int tests = 0;
  int fails = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  always #5 clk = ~clk;
  alu_operand_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && !which), .in_ready(in_ready_a), .in_data(in_data),
    .g1(g1_a), .g2(g2_a), .op(op_a), .alu_r(alu_r), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .res_valid(res_valid_a), .res_ready(res_ready && !which), .res_data(res_data_a),
    .res_zero(res_zero_a), .res_ovf(res_ovf_a), .op_count(op_count_a)
  );
  alu_operand_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && which), .in_ready(in_ready_b), .in_data(in_data),
    .g1(g1_b), .g2(g2_b), .op(op_b), .alu_r(alu_r), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .res_valid(res_valid_b), .res_ready(res_ready && which), .res_data(res_data_b),
    .res_zero(res_zero_b), .res_ovf(res_ovf_b), .op_count(op_count_b)
  );
  assign in_ready = which ? in_ready_b : in_ready_a;
  assign res_valid = which ? res_valid_b : res_valid_a;
  assign res_zero = which ? res_zero_b : res_zero_a;
  assign res_ovf = which ? res_ovf_b : res_ovf_a;
  assign g1 = which ? g1_b : g1_a;
  assign g2 = which ? g2_b : g2_a;
  assign res_data = which ? res_data_b : res_data_a;
  assign op = which ? op_b : op_a;
  assign op_count = which ? op_count_b : {6'd0, op_count_a};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Two's-complement 4-bit ALU behaviour: {overflow, zero, result}
  function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
    int sa, sb, res;
    logic [3:0] r;
    logic v;
    sa = a > 4'd7 ? int'(a) - 16 : int'(a);
    sb = b > 4'd7 ? int'(b) - 16 : int'(b);
    case (o)
      2'd0: res = sa + sb;
      2'd1: res = sa - sb;
      2'd2: res = int'(a & b);
      default: res = int'(a | b);
    endcase
    r = res[3:0];
    v = (o < 2'd2) && (res > 7 || res < -8);
    return {v, r == 4'd0, r};
  endfunction
  task automatic beat(input logic [3:0] d, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("beat_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 4'($urandom);
  endtask
  task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                     input int gap, input int hold, input bit glitch);
    logic [5:0] m;
    logic [3:0] r;
    logic z, v;
    int s;
    m = alu_ref(a, b, o);
    {v, z, r} = m;
    if (glitch) begin
      r = 4'hF; z = 1'b0; v = 1'b0; alu_r = 4'h1;
    end else alu_r = r;
    alu_zero = z;
    alu_overflow = v;
    beat(a, gap);
    beat(b, gap);
    beat({2'($urandom), o}, gap);
    s = which ? 3 : 1;
    for (int i = 0; i < s; i++) begin
      if (glitch && i == s - 1) alu_r = 4'hF;
      chk("settle_no_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    if (glitch) alu_r = 4'h7;
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_data", 32'(res_data), 32'(r));
    chk("res_zero", 32'(res_zero), 32'(z));
    chk("res_ovf", 32'(res_ovf), 32'(v));
    chk("g1", 32'(g1), 32'(gray_tab[a]));
    chk("g2", 32'(g2), 32'(gray_tab[b]));
    chk("op", 32'(op), 32'(o));
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data = 4'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'(r));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_g1", 32'(g1), 32'(gray_tab[a]));
    end
    in_valid = 1'b1;
    in_data = a ^ 4'hF;
    res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    res_ready = 1'b0;
    if (which) cnt_b = (cnt_b + 1) % 256;
    else cnt_a = (cnt_a + 1) % 4;
    chk("post_valid", 32'(res_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("op_count", 32'(op_count), 32'(which ? cnt_b : cnt_a));
    chk("post_g1", 32'(g1), 32'(gray_tab[a]));
    chk("post_g2", 32'(g2), 32'(gray_tab[b]));
    chk("post_op", 32'(op), 32'(o));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    which = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    in_data = '0;
    alu_r = '0;
    alu_zero = 1'b0;
    alu_overflow = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_g1", 32'(g1), 32'd0);
    chk("rst_g2", 32'(g2), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_res", 32'({res_data, res_zero, res_ovf}), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    txn(4'd5, 4'd3, 2'b01, 0, 0, 1'b0);
    txn(4'($urandom), 4'($urandom), 2'($urandom), 2, 5, 1'b0);
    beat(4'd9, 0);
    beat(4'd6, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    chk("mid_rst_g1", 32'(g1), 32'd0);
    chk("mid_rst_g2", 32'(g2), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 32'(res_valid), 32'd0);
    end
    for (int t = 0; t < 5; t++)
      txn(4'($urandom), 4'($urandom), 2'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    which = 1'b1;
    @(negedge clk);
    txn(4'($urandom), 4'($urandom), 2'($urandom), 0, 1, 1'b1);
    for (int t = 0; t < 3; t++)
      txn(4'($urandom), 4'($urandom), 2'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
